// File: rtl/aes_host_tx_pkg.sv
// Shared definitions for the host byte-stream transmitter: byte count per word,
// serialiser state encoding and the default byte interval.
package aes_host_tx_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_IDX       = 2'(BYTES_PER_WORD - 1);
  localparam logic [3:0] DEFAULT_DIV    = 4'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Byte idx of a word, idx 0 being the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_host_tx_word_fifo.sv
// 32-bit word FIFO with first-word fall-through output; push is ignored when
// full and pop is ignored when empty.
module aes_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [31:0]                din,
  output logic [31:0]                dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  // A pop does not free a slot for a push in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/aes_host_tx.sv
// Host-side transmitter: buffers 32-bit words and serialises each into four
// MSB-first bytes, one shi strobe per byte every div_bits+1 cycles.
module aes_host_tx
  import aes_host_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [3:0]       div_bits,
  output logic [7:0]       out_data,
  output logic             shi,
  output logic             word_done,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent,
  output state_t           dbg_state
);

  // Handshake: a word transfers on a rising edge where word_valid && word_ready;
  // the source must hold word_in stable while word_ready is low.
  logic                      w_full;
  logic                      w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic [31:0]               w_dout;
  logic                      w_push;
  logic                      w_pop;

  state_t           r_state,      w_state_nxt;
  logic [31:0]      r_sh,         w_sh_nxt;
  logic [1:0]       r_idx,        w_idx_nxt;
  logic [3:0]       r_cnt,        w_cnt_nxt;
  logic [7:0]       r_out_data,   w_out_data_nxt;
  logic             r_shi,        w_shi_nxt;
  logic             r_word_done,  w_word_done_nxt;
  logic [CNT_W-1:0] r_words_sent, w_words_sent_nxt;

  assign word_ready = !w_full;
  assign w_push     = word_valid && word_ready;

  aes_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (word_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign out_data   = r_out_data;
  assign shi        = r_shi;
  assign word_done  = r_word_done;
  assign words_sent = r_words_sent;
  assign busy       = (w_count != '0) || (r_state != ST_IDLE);
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sh         <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_out_data   <= '0;
      r_shi        <= 1'b0;
      r_word_done  <= 1'b0;
      r_words_sent <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sh         <= w_sh_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_data   <= w_out_data_nxt;
      r_shi        <= w_shi_nxt;
      r_word_done  <= w_word_done_nxt;
      r_words_sent <= w_words_sent_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sh_nxt         = r_sh;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_out_data_nxt   = r_out_data;
    w_shi_nxt        = 1'b0;
    w_word_done_nxt  = 1'b0;
    w_words_sent_nxt = r_words_sent;
    w_pop            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_sh_nxt       = w_dout;
          w_out_data_nxt = word_byte(w_dout, 2'd0);
          w_shi_nxt      = 1'b1;
          w_idx_nxt      = 2'd0;
          w_cnt_nxt      = div_bits;
          w_state_nxt    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (r_idx != LAST_IDX) begin
          w_out_data_nxt = word_byte(r_sh, r_idx + 2'd1);
          w_shi_nxt      = 1'b1;
          w_idx_nxt      = r_idx + 2'd1;
          w_cnt_nxt      = div_bits;
          // The last byte's strobe carries word_done and the count update.
          if (r_idx + 2'd1 == LAST_IDX) begin
            w_word_done_nxt  = 1'b1;
            w_words_sent_nxt = r_words_sent + CNT_W'(1);
          end
        end else if (!w_empty) begin
          w_pop          = 1'b1;
          w_sh_nxt       = w_dout;
          w_out_data_nxt = word_byte(w_dout, 2'd0);
          w_shi_nxt      = 1'b1;
          w_idx_nxt      = 2'd0;
          w_cnt_nxt      = div_bits;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
